// File: rtl/rv32_data_ram.sv
// rv32_data_ram
//   Responder side of the core's data memory bus. A request (read and/or
//   write, byte mask, byte address, write value) is latched in IDLE, held in
//   BUSY for WAIT_STATES cycles, performed on the final BUSY edge, and
//   acknowledged with a one-cycle ready_out pulse in RESP. The full 32-bit
//   word is returned; lane selection and extension stay in the initiator.
//
// Ports
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   read_in         read request
//   write_in        write request
//   write_mask_in   byte-lane write enables, bit i -> bits [8i+7:8i]
//   address_in      byte address, bits [1:0] ignored
//   write_value_in  lane-aligned write data
//   read_value_out  registered read word
//   ready_out       one-cycle completion pulse
//   fault_out       out-of-range flag, valid with ready_out
module rv32_data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        fault_out
);

    localparam int          AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [7:0]  WS = 8'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic           r_rd;
    logic           r_wr;
    logic [3:0]     r_mask;
    logic [31:0]    r_wval;
    logic           r_fault;
    logic [31:0]    r_rdata;

    logic [31:0]    r_mem [DEPTH_WORDS];

    logic [29:0]    w_word;
    logic           w_in_range;
    logic           w_req;
    logic           w_access;
    logic           w_unused;

    assign w_word     = address_in[31:2];
    // In range iff every word-index bit above the RAM index width is zero.
    assign w_in_range = ((w_word >> AW) == 30'd0);
    assign w_req      = read_in | write_in;
    assign w_access   = reset_n && (r_state == S_BUSY) && (r_cnt == 8'd0);
    assign w_unused   = &{1'b0, address_in[1:0]};

    // Control and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_mask  <= 4'd0;
            r_wval  <= 32'd0;
            r_fault <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= address_in[AW+1:2];
                        r_rd    <= read_in;
                        r_wr    <= write_in;
                        r_mask  <= write_mask_in;
                        r_wval  <= write_value_in;
                        r_fault <= !w_in_range;
                        r_cnt   <= WS;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        // RAM write happens on this same edge in the array
                        // block, so this samples the pre-write word.
                        if (r_rd)
                            r_rdata <= r_fault ? 32'd0 : r_mem[r_idx];
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_access && r_wr && !r_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mask[b])
                    r_mem[r_idx][8*b +: 8] <= r_wval[8*b +: 8];
            end
        end
    end

    assign read_value_out = r_rdata;
    assign ready_out      = (r_state == S_RESP);
    assign fault_out      = (r_state == S_RESP) && r_fault;

endmodule

// File: tb/tb_rv32_data_ram.sv
module tb_rv32_data_ram;

    localparam int NI = 3;
    localparam int WS [NI] = '{0, 3, 2};

    logic        clk = 1'b0;
    logic        rstn [NI];
    logic        rd_i [NI];
    logic        wr_i [NI];
    logic [3:0]  m_i  [NI];
    logic [31:0] a_i  [NI];
    logic [31:0] v_i  [NI];
    logic [31:0] rdat [NI];
    logic        rdy  [NI];
    logic        flt  [NI];

    always #5 clk = ~clk;

    rv32_data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset_n(rstn[0]), .read_in(rd_i[0]), .write_in(wr_i[0]),
        .write_mask_in(m_i[0]), .address_in(a_i[0]), .write_value_in(v_i[0]),
        .read_value_out(rdat[0]), .ready_out(rdy[0]), .fault_out(flt[0]));

    rv32_data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset_n(rstn[1]), .read_in(rd_i[1]), .write_in(wr_i[1]),
        .write_mask_in(m_i[1]), .address_in(a_i[1]), .write_value_in(v_i[1]),
        .read_value_out(rdat[1]), .ready_out(rdy[1]), .fault_out(flt[1]));

    rv32_data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset_n(rstn[2]), .read_in(rd_i[2]), .write_in(wr_i[2]),
        .write_mask_in(m_i[2]), .address_in(a_i[2]), .write_value_in(v_i[2]),
        .read_value_out(rdat[2]), .ready_out(rdy[2]), .fault_out(flt[2]));

    typedef struct {
        logic [31:0] d;
        logic        f;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] last_rd [NI];
    int          total = 0;
    int          bad   = 0;

    // One full transaction on instance k. Expected response is queued when
    // the request is driven and compared when ready_out appears.
    task automatic access(input int k, input bit rd, input bit wr,
                          input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] v, input logic [31:0] rd_exp,
                          input bit f_exp, input bit scramble);
        exp_t e;
        exp_t p;
        int   cyc;
        bit   got;
        e.d = rd ? rd_exp : last_rd[k];
        e.f = f_exp;
        @(posedge clk); #1;
        rd_i[k] = rd; wr_i[k] = wr; m_i[k] = m; a_i[k] = a; v_i[k] = v;
        sb.push_back(e);
        @(posedge clk); #1;
        rd_i[k] = 1'b0; wr_i[k] = 1'b0;
        cyc = 1; got = 0;
        while (!got && cyc < 40) begin
            if (scramble) begin
                a_i[k] = $urandom; v_i[k] = $urandom; m_i[k] = 4'($urandom);
            end
            @(negedge clk);
            if (rdy[k] === 1'b1) got = 1;
            else begin
                cyc++;
                if (!scramble) begin
                    a_i[k] = a_i[k];
                end
                @(posedge clk); #1;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout inst=%0d a=%h: no ready within %0d cycles", k, a, cyc);
            void'(sb.pop_front());
            return;
        end
        p = sb.pop_front();
        total++;
        if (cyc !== 2 + WS[k]) begin
            bad++;
            $display("FAIL latency inst=%0d a=%h: got %0d want %0d", k, a, cyc, 2 + WS[k]);
        end
        total++;
        if (flt[k] !== p.f) begin
            bad++;
            $display("FAIL fault inst=%0d a=%h: got %b want %b", k, a, flt[k], p.f);
        end
        total++;
        if (rdat[k] !== p.d) begin
            bad++;
            $display("FAIL rdata inst=%0d a=%h: got %h want %h", k, a, rdat[k], p.d);
        end
        if (rd) last_rd[k] = rd_exp;
        // ready must be a single-cycle pulse
        @(negedge clk);
        total++;
        if (rdy[k] !== 1'b0) begin
            bad++;
            $display("FAIL pulse inst=%0d: ready still %b one cycle after completion", k, rdy[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            rstn[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0;
            m_i[k] = 4'd0; a_i[k] = 32'd0; v_i[k] = 32'd0; last_rd[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rstn[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (rdy[k] !== 1'b0 || flt[k] !== 1'b0 || rdat[k] !== 32'd0) begin
                bad++;
                $display("FAIL reset inst=%0d: rdy=%b flt=%b rdat=%h want 0/0/0",
                         k, rdy[k], flt[k], rdat[k]);
            end
        end
    endtask

    task automatic test_basic();
        access(0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        access(0, 1, 0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    endtask

    task automatic test_byte_lanes();
        access(0, 0, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0, 0);
        access(0, 0, 1, 4'b0100, 32'h22, 32'hAABBCCDD, 32'h0, 0, 0);
        access(0, 1, 0, 4'h0, 32'h20, 32'h0, 32'h11BB3344, 0, 0);
        access(0, 0, 1, 4'b0000, 32'h20, 32'hFFFFFFFF, 32'h0, 0, 0);
        access(0, 1, 0, 4'h0, 32'h20, 32'h0, 32'h11BB3344, 0, 0);
    endtask

    task automatic test_wait_states();
        access(1, 0, 1, 4'hF, 32'h08, 32'h55AA55AA, 32'h0, 0, 0);
        access(1, 0, 1, 4'hF, 32'h0C, 32'h0BADF00D, 32'h0, 0, 0);
        access(1, 1, 0, 4'h0, 32'h08, 32'h0, 32'h55AA55AA, 0, 1);
        access(1, 1, 0, 4'h0, 32'h0C, 32'h0, 32'h0BADF00D, 0, 1);
    endtask

    task automatic test_out_of_range();
        access(0, 0, 1, 4'hF, 32'h0, 32'h01020304, 32'h0, 0, 0);
        access(0, 1, 0, 4'h0, 32'h1000, 32'h0, 32'h0, 1, 0);
        access(0, 0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 0);
        access(0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h01020304, 0, 0);
    endtask

    task automatic test_rw_simul();
        access(0, 0, 1, 4'hF, 32'h30, 32'h5, 32'h0, 0, 0);
        access(0, 1, 1, 4'hF, 32'h30, 32'h9, 32'h5, 0, 0);
        access(0, 1, 0, 4'h0, 32'h30, 32'h0, 32'h9, 0, 0);
    endtask

    // Read held high continuously: one completion per 3+WAIT_STATES cycles.
    task automatic test_back_to_back();
        int   prev;
        int   n;
        exp_t e;
        exp_t p;
        access(1, 0, 1, 4'hF, 32'h40, 32'h600DCAFE, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            e.d = 32'h600DCAFE; e.f = 1'b0; sb.push_back(e);
        end
        @(posedge clk); #1;
        rd_i[1] = 1'b1; m_i[1] = 4'h0; a_i[1] = 32'h40; v_i[1] = 32'h0;
        prev = -1; n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            if (rdy[1] === 1'b1) begin
                p = sb.pop_front();
                total++;
                if (rdat[1] !== p.d || flt[1] !== p.f) begin
                    bad++;
                    $display("FAIL b2b_data: got %h/%b want %h/%b", rdat[1], flt[1], p.d, p.f);
                end
                if (prev >= 0) begin
                    total++;
                    if (c - prev !== 3 + WS[1]) begin
                        bad++;
                        $display("FAIL b2b_interval: got %0d want %0d", c - prev, 3 + WS[1]);
                    end
                end
                prev = c; n++;
            end
        end
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d completions want 3", n);
            sb.delete();
        end
        @(posedge clk); #1;
        rd_i[1] = 1'b0;
        // drain a possibly accepted trailing read
        repeat (8) @(posedge clk);
        last_rd[1] = 32'h600DCAFE;
    endtask

    task automatic test_reset_mid();
        bit seen;
        access(2, 0, 1, 4'hF, 32'h44, 32'h12345678, 32'h0, 0, 0);
        access(2, 1, 0, 4'h0, 32'h44, 32'h0, 32'h12345678, 0, 0);
        @(posedge clk); #1;
        wr_i[2] = 1'b1; m_i[2] = 4'hF; a_i[2] = 32'h44; v_i[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        wr_i[2] = 1'b0;
        #1 rstn[2] = 1'b0;
        #1;
        total++;
        if (rdy[2] !== 1'b0 || flt[2] !== 1'b0 || rdat[2] !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: rdy=%b flt=%b rdat=%h want 0/0/0",
                     rdy[2], flt[2], rdat[2]);
        end
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[2] === 1'b1) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_mid_noready: ready pulse seen after reset, want none");
        end
        last_rd[2] = 32'd0;
        access(2, 1, 0, 4'h0, 32'h44, 32'h0, 32'h12345678, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_out_of_range();
        test_rw_simul();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rv32_data_ram.md
Name: rv32_data_ram

Overview:
- Responder end of the core's data memory bus: services the read/write requests the memory stage issues (read, write, byte-lane mask, address, write value) from a word-organised on-chip RAM.
- Returns the full 32-bit word. Lane selection and sign/zero extension stay in the initiator.
- Registered, multi-cycle access with a programmable number of wait states. Signals completion with ready_out so the hazard logic can stall the pipeline until the access is done.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 2.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and the access; range 0..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- read_in  input  1  read request.
- write_in  input  1  write request.
- write_mask_in  input  4  byte-lane write enables; bit i enables bits [8i+7:8i].
- address_in  input  32  byte address; bits [1:0] ignored.
- write_value_in  input  32  write data, lane-aligned by the initiator.
- read_value_out  output  32  read word, registered.
- ready_out  output  1  one-cycle completion pulse.
- fault_out  output  1  out-of-range flag, valid while ready_out=1.

Behaviour:
- Reset (reset_n=0, immediate):
  - state=IDLE, ready_out=0, fault_out=0, read_value_out=0, wait counter=0.
  - RAM contents are not reset.
- Word index = address_in[31:2]. The request is in range iff index < DEPTH_WORDS.
- State IDLE:
  - If read_in|write_in, latch address, kind, mask and write value, load counter=WAIT_STATES, and go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY:
  - Input changes are ignored; only the latched copy is used.
  - If counter≠0: decrement and stay in BUSY.
  - If counter=0, perform the access at this edge and go to RESP:
    - Write: for each mask bit set, update that byte lane of the word.
    - Read: register the addressed word into read_value_out.
- State RESP:
  - ready_out=1 and fault_out=fault for exactly this cycle.
  - Next state is always IDLE. A request present during RESP is ignored, because it belongs to the transaction just completed.
- Latency: request seen in cycle N → ready_out high in cycle N+2+WAIT_STATES.
- Back-to-back throughput: one access per 3+WAIT_STATES cycles.
- ready_out and fault_out are decoded from registered state only; no combinational path from inputs.
- read_value_out:
  - Changes only on a completing read.
  - Holds its value across writes, idle cycles and faults, except that an out-of-range read loads 0.
- Simultaneous read_in and write_in:
  - The write is performed.
  - read_value_out receives the pre-write word (read-before-write).
- write_mask_in=0 with write_in: completes normally (ready pulse), RAM unchanged.
- Out-of-range access:
  - No RAM update; a read returns 0.
  - fault_out=1 alongside ready_out.
  - Wait-state timing is unchanged.
- Reset asserted in BUSY before the access edge: the pending write is discarded, no ready pulse, state=IDLE.
- Counter width is 8 bits; no wrap, since it is only loaded with WAIT_STATES and counts down to 0.

Test Plan:
- WAIT_STATES=0: write addr 0x10, value 0xDEADBEEF, mask 4'b1111 in cycle 0 → ready_out=1 in cycle 2, fault_out=0. Then read 0x10 → ready_out in cycle 2 of that access, read_value_out=0xDEADBEEF.
- Byte lanes: preload 0x11223344 at 0x20. Write value 0xAABBCCDD, mask 4'b0100, address 0x22 → subsequent read returns 0x11BB3344. Mask 4'b0000 write → word unchanged, ready pulse still seen.
- WAIT_STATES=3: read issued in cycle 0 → ready_out low in cycles 1–4, high only in cycle 5. Changing address_in during cycles 1–4 does not alter the returned word.
- Out of range with DEPTH_WORDS=1024: read 0x00001000 → ready_out with fault_out=1, read_value_out=0. Write to 0x00001000 → fault_out=1, and word 0 (aliased index) is unchanged.
- Simultaneous read_in=1, write_in=1 at a word holding 0x00000005, value 0x00000009 → read_value_out=0x00000005; later read returns 0x00000009.
- Reset mid-operation (WAIT_STATES=2): write 0xCAFEF00D issued, reset_n pulsed low in cycle 1 → no ready pulse, outputs 0 immediately, and a later read of that address shows the old contents.
